// File: rtl/spm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spm_mem_arbiter
// Description : Shares the single-port RISC_SPM program/data memory between
//               the CPU and a host loader port. Round-robin arbitration with
//               one granted access per cycle and a one-cycle read latency.
//               When the ARB_FLUSH_EN macro is defined, a flush engine can
//               clear the entire memory. It writes zero to addresses
//               0..MEM_DEPTH-1, one address per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid           CPU grant (comb), read data valid (reg)
//   host_req/we/addr/wdata        host request (held until host_gnt)
//   host_gnt, host_rvalid         host grant (comb), read data valid (reg)
//   rdata                         shared read data, qualified by *_rvalid
//   mem_en/we/addr/wdata          memory strobe, write enable, address, data
//   mem_rdata                     memory read data, one cycle after a read
//   flush_start                   one-cycle pulse requesting a full clear
//   flush_busy, flush_done        flush in progress / completion pulse
// Configuration
//   ARB_FLUSH_EN  defined  : flush engine and FLUSH state present
//                 undefined: flush_start ignored, flush_busy/flush_done stay 0
// ============================================================================
module spm_mem_arbiter #(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [addr_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [addr_size-1:0] host_addr,
  input  logic [word_size-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [word_size-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata,
  input  logic                 flush_start,
  output logic                 flush_busy,
  output logic                 flush_done
);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // last_grant encoding: which requester was granted most recently
  localparam logic LAST_CPU  = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(MEM_DEPTH - 1);

  state_t               state, state_next;
  logic                 last_grant, last_grant_next;
  logic [addr_size-1:0] flush_cnt, flush_cnt_next;
  logic                 flush_done_r, flush_done_next;
  logic                 cpu_win, host_win;
  logic                 flush_go;

`ifdef ARB_FLUSH_EN
  assign flush_go = flush_start;
`else
  // Without the flush engine the FSM never leaves ARB, so flush_busy and
  // flush_done are constant 0 and the flush logic reduces away.
  logic unused_flush_start;
  assign flush_go           = 1'b0;
  assign unused_flush_start = flush_start;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: a lone requester wins immediately; under contention the
  // requester that was not granted last time wins. Grants are suppressed
  // while in reset or while flushing.
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (rst && (state == ARB)) begin
      if (cpu_req && host_req) begin
        cpu_win  = (last_grant == LAST_HOST);
        host_win = (last_grant == LAST_CPU);
      end else begin
        cpu_win  = cpu_req;
        host_win = host_req;
      end
    end
  end

  assign cpu_gnt  = cpu_win;
  assign host_gnt = host_win;

  // --------------------------------------------------------------------------
  // Memory port mux: the flush engine owns the port while flushing, otherwise
  // the winning requester drives it. Idle cycles drive all zeros.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (state == FLUSH) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = flush_cnt;
        mem_wdata = '0;
      end else if (cpu_win) begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else if (host_win) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    flush_cnt_next  = flush_cnt;
    flush_done_next = 1'b0;

    if (cpu_win) begin
      last_grant_next = LAST_CPU;
    end else if (host_win) begin
      last_grant_next = LAST_HOST;
    end

    case (state)
      ARB: begin
        // Arbitration still runs in the cycle flush_start arrives, so a read
        // granted here returns its data during the first flush cycle.
        if (flush_go) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt == LAST_ADDR) begin
          state_next      = ARB;
          flush_cnt_next  = '0;
          flush_done_next = 1'b1;
          // Requests that waited out the flush resolve in favour of the CPU.
          last_grant_next = LAST_HOST;
        end else begin
          flush_cnt_next = flush_cnt + 1'b1;
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ARB;
      last_grant   <= LAST_HOST;
      flush_cnt    <= '0;
      flush_done_r <= 1'b0;
      cpu_rvalid   <= 1'b0;
      host_rvalid  <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      flush_cnt    <= flush_cnt_next;
      flush_done_r <= flush_done_next;
      // Read data comes back one cycle after the strobe; flag its owner.
      cpu_rvalid   <= cpu_win  & ~cpu_we;
      host_rvalid  <= host_win & ~host_we;
    end
  end

  assign rdata      = mem_rdata;
  assign flush_busy = (state == FLUSH);
  assign flush_done = flush_done_r;

endmodule
`default_nettype wire

// File: tb/tb_spm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_mem_arbiter
// Description : Self-checking bench for spm_mem_arbiter with a behavioural
//               single-port memory. Expected read data is queued per
//               requester when a read is granted and is checked when the
//               matching rvalid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       flush_start, flush_busy, flush_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] cpu_exp[$];
  logic [7:0] host_exp[$];

  always #5 clk = ~clk;

  spm_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .flush_start(flush_start),
    .flush_busy (flush_busy),
    .flush_done (flush_done)
  );

  // Behavioural single-port memory, read latency 1
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Response monitor: every rvalid must match the head of its owner's queue
  always @(negedge clk) begin
    logic [7:0] e;
    if (cpu_rvalid === 1'b1) begin
      vectors++;
      if (cpu_exp.size() == 0) begin
        miscompares++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid=1 rdata=%h, required no rvalid", rdata);
      end else begin
        e = cpu_exp.pop_front();
        if (rdata !== e) begin
          miscompares++;
          $display("FAIL cpu_rdata: got %h, required %h", rdata, e);
        end
      end
    end
    if (host_rvalid === 1'b1) begin
      vectors++;
      if (host_exp.size() == 0) begin
        miscompares++;
        $display("FAIL host_rvalid_unexpected: got rvalid=1 rdata=%h, required no rvalid", rdata);
      end else begin
        e = host_exp.pop_front();
        if (rdata !== e) begin
          miscompares++;
          $display("FAIL host_rdata: got %h, required %h", rdata, e);
        end
      end
    end
  end

  // Driver: one access, held until granted (bounded); queues read data on grant
  task automatic access(input bit host, input bit we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp, output bit ok);
    ok = 1'b0;
    if (host) begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; end
    else      begin cpu_req  = 1'b1; cpu_we  = we; cpu_addr  = a; cpu_wdata  = d; end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if ((host ? host_gnt : cpu_gnt) === 1'b1) begin
        ok = 1'b1;
        if (!we) begin
          if (host) host_exp.push_back(exp);
          else      cpu_exp.push_back(exp);
        end
      end
      @(posedge clk); #1;
    end
    if (host) host_req = 1'b0;
    else      cpu_req  = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b0;
    cpu_addr = 8'd1; host_addr = 8'd2;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, flush_busy} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got gnt/gnt/rv/rv/en/busy=%b, required 000000",
                 {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, flush_busy});
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0; rst = 1'b1;
  endtask

  task automatic test_cpu_read();
    bit ok;
    access(1'b1, 1'b1, 8'd129, 8'd6, 8'h00, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL cpu_read_preload: got no host_gnt, required grant"); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd129;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, host_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 8'd129) begin
      miscompares++;
      $display("FAIL cpu_read_grant: got gnt=%b/%b en=%b we=%b addr=%0d, required 1/0 1 0 129",
               cpu_gnt, host_gnt, mem_en, mem_we, mem_addr);
    end
    if (cpu_gnt === 1'b1) cpu_exp.push_back(8'd6);
    @(posedge clk); #1; cpu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL cpu_read_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    bit exp_cpu;
    access(1'b1, 1'b1, 8'd10, 8'hA1, 8'h00, ok);
    access(1'b1, 1'b1, 8'd11, 8'hB2, 8'h00, ok);
    apply_reset(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_cpu = (i % 2 == 0);
      vectors++;
      if ({cpu_gnt, host_gnt} !== {exp_cpu, ~exp_cpu}) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got cpu/host=%b%b, required %b%b", i, cpu_gnt, host_gnt, exp_cpu, ~exp_cpu);
      end
      if (exp_cpu) cpu_exp.push_back(8'hA1);
      else         host_exp.push_back(8'hB2);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL rr_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask

  task automatic test_write_then_read();
    bit ok;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd139; host_wdata = 8'hF0;
    @(negedge clk);
    vectors++;
    if ({host_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 8'd139 || mem_wdata !== 8'hF0) begin
      miscompares++;
      $display("FAIL host_write: got gnt=%b en=%b we=%b addr=%0d wdata=%h, required 1 1 1 139 f0",
               host_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1; host_req = 1'b0;
    access(1'b0, 1'b0, 8'd139, 8'h00, 8'hF0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wr_rd_grant: got no cpu_gnt, required grant"); end
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL wr_rd_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 8'h11 * 8'(k + 1);
      access(1'b1, 1'b1, 8'(20 + k), d, 8'h00, ok);
    end
    cpu_req = 1'b1; cpu_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_addr = 8'(20 + k);
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_addr !== 8'(20 + k)) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got gnt=%b addr=%0d, required 1 %0d", k, cpu_gnt, mem_addr, 20 + k);
      end
      cpu_exp.push_back(8'h11 * 8'(k + 1));
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask

`ifdef ARB_FLUSH_EN
  task automatic test_flush();
    bit ok;
    bit done_seen;
    int busy_cycles;
    int bad;
    access(1'b1, 1'b1, 8'd128, 8'd5, 8'h00, ok);
    // Host read granted in the flush_start cycle must still return data
    flush_start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd20;
    @(negedge clk);
    vectors++;
    if (host_gnt !== 1'b1 || flush_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_cycle: got gnt=%b busy=%b, required 1 0", host_gnt, flush_busy);
    end
    if (host_gnt === 1'b1) host_exp.push_back(8'h11);
    @(posedge clk); #1;
    flush_start = 1'b0; host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd128;
    busy_cycles = 0; bad = 0; done_seen = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      @(negedge clk);
      if (flush_done === 1'b1) begin
        done_seen = 1'b1;
      end else if (flush_busy === 1'b1) begin
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_wdata !== 8'h00 || mem_addr !== 8'(busy_cycles)) bad++;
        busy_cycles++;
      end
      if (!done_seen) begin
        @(posedge clk); #1;
        flush_start = (busy_cycles == 50);
      end
    end
    flush_start = 1'b0;
    vectors++;
    if (!done_seen || busy_cycles != 256) begin
      miscompares++;
      $display("FAIL flush_length: got done=%b busy_cycles=%0d, required 1 256", done_seen, busy_cycles);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flush_cycles: got %0d bad flush cycles, required 0", bad);
    end
    vectors++;
    if (cpu_gnt !== 1'b1 || flush_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_exit_grant: got gnt=%b busy=%b, required 1 0", cpu_gnt, flush_busy);
    end
    if (cpu_gnt === 1'b1) cpu_exp.push_back(8'h00);
    @(posedge clk); #1; cpu_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_pulse: got %b one cycle later, required 0", flush_done);
    end
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL flush_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask

  task automatic test_flush_reset();
    bit ok;
    bit reached;
    int bad;
    access(1'b1, 1'b1, 8'd200, 8'h3C, 8'h00, ok);
    flush_start = 1'b1;
    @(posedge clk); #1; flush_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (flush_busy === 1'b1 && mem_addr === 8'd100) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL flush_reach_100: got no flush cycle 100, required one"); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (flush_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_abort_busy: got %b, required 0", flush_busy);
    end
    rst = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (flush_done !== 1'b0 || flush_busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flush_abort_done: got %0d cycles with busy/done, required 0", bad);
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 8'd200, 8'h00, 8'h3C, ok);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || host_exp.size() != 0) begin
      miscompares++;
      $display("FAIL flush_reset_drain: got %0d/%0d pending, required 0/0", cpu_exp.size(), host_exp.size());
      cpu_exp.delete(); host_exp.delete();
    end
  endtask
`else
  task automatic test_flush_disabled();
    flush_start = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd20;
    @(negedge clk);
    vectors++;
    if (cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL noflush_grant0: got %b, required 1", cpu_gnt); end
    if (cpu_gnt === 1'b1) cpu_exp.push_back(8'h11);
    @(posedge clk); #1;
    flush_start = 1'b0; cpu_addr = 8'd21;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, flush_busy, flush_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL noflush_grant1: got gnt/busy/done=%b, required 100", {cpu_gnt, flush_busy, flush_done});
    end
    if (cpu_gnt === 1'b1) cpu_exp.push_back(8'h22);
    @(posedge clk); #1; cpu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cpu_exp.size() != 0 || flush_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL noflush_drain: got %0d pending busy=%b, required 0 0", cpu_exp.size(), flush_busy);
      cpu_exp.delete();
    end
  endtask
`endif

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; flush_start = 1'b0;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_write_then_read();
    test_back_to_back();
`ifdef ARB_FLUSH_EN
    test_flush();
    test_flush_reset();
`else
    test_flush_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
